// File: rtl/bsh_arb_ctrl.sv
// Two-requester barrel-shift service: arbitrates two request ports onto one shared
// 32-bit shifter through a two-stage issue/response pipeline with saturating counters.

module bsh_32 (
  input  logic [31:0] data,
  input  logic [4:0]  sh,
  input  logic        dir,
  output logic [31:0] result
);
  // dir=1 shifts toward the LSB; both directions zero-fill.
  assign result = dir ? (data >> sh) : (data << sh);
endmodule

module bsh_arb_ctrl #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic             req0_op,
  input  logic [4:0]       req0_sh,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic             req1_op,
  input  logic [4:0]       req1_sh,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        v1, v2;
  logic [31:0] s1_data;
  logic        s1_op;
  logic [4:0]  s1_sh;
  logic        s1_id;
  logic [31:0] s2_result;
  logic        s2_id;
  logic        last_id;
  logic        adv1, adv2;
  logic        gnt0, gnt1;
  logic        acc0, acc1;
  logic        rsp_fire;
  logic [31:0] shift_out;

  assign adv2 = !v2 || rsp_ready;
  assign adv1 = !v1 || adv2;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN != 0) begin
        gnt0 = last_id;
        gnt1 = !last_id;
      end else begin
        gnt0 = 1'b1;
      end
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Readies are combinational, so they are gated by rst_n to stay low during reset.
  assign req0_ready = rst_n && gnt0 && adv1;
  assign req1_ready = rst_n && gnt1 && adv1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign rsp_fire   = v2 && rsp_ready;

  bsh_32 u_bsh (
    .data   (s1_data),
    .sh     (s1_sh),
    .dir    (s1_op),
    .result (shift_out)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_data   <= '0;
      s1_op     <= 1'b0;
      s1_sh     <= '0;
      s1_id     <= 1'b0;
      v2        <= 1'b0;
      s2_result <= '0;
      s2_id     <= 1'b0;
      last_id   <= 1'b1;
    end else begin
      if (adv1) begin
        v1 <= acc0 || acc1;
        if (acc0 || acc1) begin
          s1_data <= acc1 ? req1_data : req0_data;
          s1_op   <= acc1 ? req1_op   : req0_op;
          s1_sh   <= acc1 ? req1_sh   : req0_sh;
          s1_id   <= acc1;
          last_id <= acc1;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_result <= shift_out;
          s2_id     <= s1_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (rsp_fire) begin
      if (!s2_id && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
      if (s2_id  && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign rsp_valid = v2;
  assign rsp_data  = s2_result;
  assign rsp_id    = s2_id;

endmodule

// File: tb/tb_bsh_arb_ctrl.sv
// Directed bench for bsh_arb_ctrl: a round-robin instance and a fixed-priority,
// 2-bit-counter instance driven from the same stimulus.

module tb_bsh_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_op, req1_op;
  logic [4:0]  req0_sh, req1_sh;
  logic        rsp_ready;

  logic        r0_ready, r1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_data;
  logic [15:0] cnt0, cnt1;

  logic        f0_ready, f1_ready, f_valid, f_id;
  logic [31:0] f_data;
  logic [1:0]  f_cnt0, f_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsh_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_ready), .req0_data(req0_data),
    .req0_op(req0_op), .req0_sh(req0_sh),
    .req1_valid(req1_valid), .req1_ready(r1_ready), .req1_data(req1_data),
    .req1_op(req1_op), .req1_sh(req1_sh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .cnt0(cnt0), .cnt1(cnt1)
  );

  bsh_arb_ctrl #(.RR_EN(0), .CNT_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f0_ready), .req0_data(req0_data),
    .req0_op(req0_op), .req0_sh(req0_sh),
    .req1_valid(req1_valid), .req1_ready(f1_ready), .req1_data(req1_data),
    .req1_op(req1_op), .req1_sh(req1_sh),
    .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_data(f_data),
    .rsp_id(f_id), .cnt0(f_cnt0), .cnt1(f_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_id [4];
    logic [31:0] exp_dat [4];
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_dat = '{32'h2, 32'h10, 32'h2, 32'h10};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = '0; req0_op = 1'b0; req0_sh = '0;
    req1_valid = 1'b0; req1_data = '0; req1_op = 1'b0; req1_sh = '0;
    #3;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_cnt0",      32'(cnt0),      32'd0);
    check("rst_cnt1",      32'(cnt1),      32'd0);
    check("rst_req0_ready", 32'(r0_ready), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single requester: 1 << 31
    req0_valid = 1'b1; req0_data = 32'h1; req0_op = 1'b0; req0_sh = 5'd31;
    #1;
    check("t1_req0_ready", 32'(r0_ready), 32'd1);
    tick(); req0_valid = 1'b0;
    check("t1_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data",  rsp_data,       32'h8000_0000);
    check("t1_id",    32'(rsp_id),    32'd0);
    tick();
    check("t1_drained", 32'(rsp_valid), 32'd0);
    check("t1_cnt0",    32'(cnt0),      32'd1);

    // Requester 1: right shift then passthrough, back to back
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_op = 1'b1; req1_sh = 5'd4;
    tick();
    req1_data = 32'hDEAD_BEEF; req1_sh = 5'd0;
    tick(); req1_valid = 1'b0;
    check("t2_data_a", rsp_data,    32'h0800_0000);
    check("t2_id_a",   32'(rsp_id), 32'd1);
    tick();
    check("t2_data_b", rsp_data,    32'hDEAD_BEEF);
    check("t2_id_b",   32'(rsp_id), 32'd1);
    tick();
    check("t2_drained", 32'(rsp_valid), 32'd0);
    check("t2_cnt1",    32'(cnt1),      32'd2);

    // Contention: round-robin alternates, fixed priority always picks req0
    tick(); do_reset();
    req0_valid = 1'b1; req0_data = 32'h1;   req0_op = 1'b0; req0_sh = 5'd1;
    req1_valid = 1'b1; req1_data = 32'h100; req1_op = 1'b1; req1_sh = 5'd4;
    #1;
    check("t3_rr_first_req0", 32'(r0_ready), 32'd1);
    check("t3_rr_first_req1", 32'(r1_ready), 32'd0);
    check("t3_fp_req1_ready", 32'(f1_ready), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (e >= 2) begin
        check($sformatf("t3_rr_id%0d", e - 2), 32'(rsp_id), 32'(exp_id[e-2]));
        check($sformatf("t3_rr_data%0d", e - 2), rsp_data, exp_dat[e-2]);
        check($sformatf("t3_fp_id%0d", e - 2), 32'(f_id), 32'd0);
      end
    end
    tick();
    check("t3_rr_cnt0", 32'(cnt0),   32'd2);
    check("t3_rr_cnt1", 32'(cnt1),   32'd2);
    check("t3_fp_sat4", 32'(f_cnt0), 32'd3);
    req0_valid = 1'b1;
    tick(); req0_valid = 1'b0;
    tick(); tick();
    check("t3_fp_sat5", 32'(f_cnt0), 32'd3);
    check("t3_rr_cnt0b", 32'(cnt0),  32'd3);

    // Backpressure: two accepted, then stall with stable output, then ordered drain
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h3; req0_op = 1'b0; req0_sh = 5'd2;
    tick();
    req0_data = 32'h5; req0_sh = 5'd4;
    tick();
    req0_data = 32'hF0; req0_op = 1'b1; req0_sh = 5'd4;
    check("t4_valid",    32'(rsp_valid), 32'd1);
    check("t4_data_s1",  rsp_data,       32'hC);
    check("t4_ready_lo", 32'(r0_ready),  32'd0);
    tick();
    check("t4_data_s2",   rsp_data,      32'hC);
    check("t4_ready_lo2", 32'(r0_ready), 32'd0);
    rsp_ready = 1'b1;
    #1;
    check("t4_ready_rel", 32'(r0_ready), 32'd1);
    tick(); req0_valid = 1'b0;
    check("t4_drain_b", rsp_data, 32'h50);
    tick();
    check("t4_drain_c", rsp_data, 32'hF);
    tick();
    check("t4_empty", 32'(rsp_valid), 32'd0);
    check("t4_cnt0",  32'(cnt0),      32'd3);

    // Reset with both stages full
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h1; req1_op = 1'b0; req1_sh = 5'd1;
    tick(); tick(); req1_valid = 1'b0;
    check("t5_full", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_cnt0",  32'(cnt0),      32'd0);
    check("t5_rst_data",  rsp_data,       32'd0);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_no_stale%0d", i), 32'(rsp_valid), 32'd0);
    end
    check("t5_cnt1", 32'(cnt1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
